// File: rtl/bsg_two_fifo_pkg.sv
// Shared constants and types for the two-entry elastic buffer.
package bsg_two_fifo_pkg;

    localparam int unsigned BSG_TWO_FIFO_WIDTH = 13;
    localparam int unsigned BSG_TWO_FIFO_ELS   = 2;

    // One bit is enough to address two storage slots.
    typedef logic bsg_two_fifo_ptr_t;

    typedef struct packed {
        logic full;
        logic empty;
    } bsg_two_fifo_flags_s;

    localparam bsg_two_fifo_flags_s BSG_TWO_FIFO_FLAGS_RESET = '{full: 1'b0, empty: 1'b1};

endpackage

// File: rtl/bsg_dff_en_async_reset.sv
// Enabled register with asynchronous active-high reset to zero.
module bsg_dff_en_async_reset #(
    parameter int unsigned width_p = 13
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    // Capture data_i when enabled; cleared immediately on reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_two_fifo_async_reset_width_p13.sv
// Two-entry ready/valid -> valid/yumi elastic buffer with asynchronous reset.
// Outputs depend on registered state only (ready_o also gated by reset_i).
module bsg_two_fifo_async_reset_width_p13
    import bsg_two_fifo_pkg::*;
#(
    parameter int unsigned width_p = BSG_TWO_FIFO_WIDTH,
    parameter int unsigned els_p   = BSG_TWO_FIFO_ELS
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    if (els_p != BSG_TWO_FIFO_ELS) begin : g_els_check
        $error("bsg_two_fifo_async_reset_width_p13: els_p must be 2");
    end

    bsg_two_fifo_ptr_t   wptr_q, wptr_d;
    bsg_two_fifo_ptr_t   rptr_q, rptr_d;
    bsg_two_fifo_flags_s flags_q, flags_d;

    logic [width_p-1:0] mem0_q, mem1_q;
    logic               enq, deq;

    assign ready_o = ~flags_q.full & ~reset_i;
    assign v_o     = ~flags_q.empty;
    assign data_o  = rptr_q ? mem1_q : mem0_q;

    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    bsg_dff_en_async_reset #(.width_p(width_p)) mem0_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (enq & ~wptr_q),
        .data_i  (data_i),
        .data_o  (mem0_q)
    );

    bsg_dff_en_async_reset #(.width_p(width_p)) mem1_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (enq & wptr_q),
        .data_i  (data_i),
        .data_o  (mem1_q)
    );

    // Next pointers and flags; simultaneous enq/deq leaves occupancy unchanged.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        flags_d = flags_q;
        if (enq) begin
            wptr_d = ~wptr_q;
        end
        if (deq) begin
            rptr_d = ~rptr_q;
        end
        if (enq && !deq) begin
            flags_d.empty = 1'b0;
            flags_d.full  = (wptr_d == rptr_q);
        end else if (deq && !enq) begin
            flags_d.full  = 1'b0;
            flags_d.empty = (rptr_d == wptr_q);
        end
    end

    // Pointer and flag state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            flags_q <= BSG_TWO_FIFO_FLAGS_RESET;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            flags_q <= flags_d;
        end
    end

`ifndef SYNTHESIS
    a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
        else $error("yumi_i asserted while v_o=0");
    a_ctrl_known : assert property (@(posedge clk_i) disable iff (reset_i) !$isunknown({v_i, yumi_i}))
        else $error("X on v_i/yumi_i");
`endif

endmodule

// File: tb/tb_bsg_two_fifo_async_reset_width_p13.sv
// Randomised and directed bench for the two-entry elastic buffer, checked
// against a queue-based occupancy model.
module tb_bsg_two_fifo_async_reset_width_p13;

    localparam int unsigned W = 13;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         v_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         ready_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi_i = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model: FIFO contents in order; data_o known to be zero until first enqueue after reset.
    logic [W-1:0] model_q[$];
    bit           zero_known = 1'b1;

    bsg_two_fifo_async_reset_width_p13 #(.width_p(W), .els_p(2)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ready"}, 32'(ready_o), 32'((model_q.size() < 2) && !reset_i));
        check({tag, ".v"}, 32'(v_o), 32'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            check({tag, ".data"}, 32'(data_o), 32'(model_q[0]));
        end else if (zero_known) begin
            check({tag, ".data0"}, 32'(data_o), 32'd0);
        end
    endtask

    // Drive one cycle of stimulus, check at the negedge, update the model at the posedge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic y, input string tag);
        bit enq, deq;
        v_i = v;
        data_i = d;
        yumi_i = y;
        if (reset_i) begin
            model_q.delete();
            zero_known = 1'b1;
        end
        @(negedge clk_i);
        check_outputs(tag);
        @(posedge clk_i);
        enq = v && (model_q.size() < 2) && !reset_i;
        deq = y && (model_q.size() > 0) && !reset_i;
        if (deq) void'(model_q.pop_front());
        if (enq) begin
            model_q.push_back(d);
            zero_known = 1'b0;
        end
        #1;
    endtask

    function automatic logic yumi_ok();
        return logic'(model_q.size() > 0);
    endfunction

    initial begin
        // Reset held for three cycles, then idle.
        for (int i = 0; i < 3; i++) step(1'b1, W'(13'h1FFF), 1'b0, "rst_hold");
        reset_i = 1'b0;
        step(1'b0, '0, 1'b0, "rst_rel");

        // Single transfer.
        step(1'b1, 13'h1ABC, 1'b0, "single_enq");
        step(1'b0, '0, 1'b1, "single_deq");
        step(1'b0, '0, 1'b0, "single_after");

        // Fill and backpressure.
        step(1'b1, 13'h0001, 1'b0, "fill1");
        step(1'b1, 13'h0002, 1'b0, "fill2");
        step(1'b1, 13'h0003, 1'b0, "fill_bp");
        step(1'b0, '0, 1'b1, "drain1");
        step(1'b0, '0, 1'b1, "drain2");
        step(1'b0, '0, 1'b0, "drained");

        // Streaming at full rate.
        for (int i = 0; i < 20; i++) step(1'b1, W'(i), yumi_ok(), "stream");
        while (model_q.size() > 0) step(1'b0, '0, 1'b1, "stream_drain");

        // Simultaneous enq/deq while holding one entry.
        step(1'b1, 13'h0AAA, 1'b0, "sim_load");
        step(1'b1, 13'h0BBB, 1'b1, "sim_both");
        step(1'b0, '0, 1'b0, "sim_after");
        check("sim_data", 32'(data_o), 32'h0BBB);
        step(1'b0, '0, 1'b1, "sim_drain");
        step(1'b0, '0, 1'b0, "sim_empty");

        // Asynchronous reset mid-cycle while full.
        step(1'b1, 13'h1111, 1'b0, "ar_fill1");
        step(1'b1, 13'h1222, 1'b0, "ar_fill2");
        #2;
        reset_i = 1'b1;
        #1;
        check("ar_v", 32'(v_o), 32'd0);
        check("ar_data", 32'(data_o), 32'd0);
        check("ar_ready", 32'(ready_o), 32'd0);
        step(1'b1, 13'h1333, 1'b0, "ar_hold");
        step(1'b0, '0, 1'b0, "ar_hold2");
        reset_i = 1'b0;
        step(1'b0, '0, 1'b0, "ar_rel");

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_i = 1'b1;
                step(1'($urandom_range(0, 1)), W'($urandom_range(0, 8191)), 1'b0, "rnd_rst");
                reset_i = 1'b0;
            end
            step(1'($urandom_range(0, 1)), W'($urandom_range(0, 8191)),
                 1'($urandom_range(0, 1)) & yumi_ok(), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_two_fifo_async_reset_width_p13.md
Name: bsg_two_fifo_async_reset_width_p13

Overview:
- Two-entry ready/valid elastic buffer. It is the draining, consumer-facing counterpart to the plain reset register stage.
- Producer side: valid/ready handshake. Consumer side: valid/yumi handshake (valid-then-yumi).
- Decouples timing between pipeline stages in the same datapath and sustains 1 transfer/cycle at full throughput.
- No combinational path from input to output, or from yumi_i to ready_o.

Parameters:
- width_p, 13, payload width in bits.
- els_p, 2, storage depth. Fixed at 2; any other value is a tie-off error flagged by an elaboration assertion.

Ports:
- clk_i  input  1  single clock; all state updates on posedge.
- reset_i  input  1  asynchronous, active-high reset.
- v_i  input  1  producer data valid.
- data_i  input  width_p  producer payload.
- ready_o  output  1  buffer can accept; enqueue occurs when v_i & ready_o.
- v_o  output  1  buffer holds data for the consumer.
- data_o  output  width_p  head-of-queue payload.
- yumi_i  input  1  consumer takes the head this cycle; legal only when v_o=1.

Behaviour:
- Interface (already decided): one clock, clk_i; reset reset_i is asynchronous and active-high.
- State:
  - mem0/mem1 (width_p each)
  - wptr, rptr (1 bit each)
  - full, empty flags
- Reset (async assert, takes effect immediately, independent of clk_i):
  - wptr=rptr=0, empty=1, full=0, mem0=mem1=0.
  - Outputs during and after reset: v_o=0, data_o=0.
  - ready_o=0 while reset_i=1. ready_o=1 in the first cycle after deassertion.
  - Reset asserted mid-operation discards all stored entries. No partial update survives.
- Outputs (combinational from state only):
  - ready_o = ~full & ~reset_i
  - v_o = ~empty
  - data_o = mem[rptr]
- Enqueue (enq = v_i & ready_o):
  - mem[wptr] <= data_i; wptr toggles.
- Dequeue (deq = yumi_i & v_o):
  - rptr toggles. Memory is not cleared.
- Flag update per cycle:
  - enq only: empty<=0; full<=(wptr_next==rptr).
  - deq only: full<=0; empty<=(rptr_next==wptr).
  - enq and deq together: flags unchanged, both pointers advance.
- Latency: data enqueued at cycle N is visible on data_o with v_o=1 at cycle N+1. There is no bypass path when empty.
- Full: ready_o=0. A simultaneous yumi_i frees a slot, but ready_o does not reflect it until the next cycle (no yumi->ready path).
- Empty: v_o=0 and data_o holds stale mem[rptr]. The consumer must not sample data_o.
- Pointer wrap: 1-bit pointers wrap naturally 1->0.
- Protocol violations:
  - yumi_i=1 with v_o=0: ignored, state unchanged; a simulation assertion fires.
  - v_i=1 with ready_o=0: not an enqueue, data dropped, no state change. This is legal; the producer must hold the data.
- X-handling: data_i may be X when v_i=0. X on v_i/yumi_i outside reset is an assertion error.

Decomposition:
- Shared package bsg_two_fifo_pkg:
  - constant default width 13
  - constant els 2
  - typedef for the 1-bit pointer
  - typedef struct for the flag pair {full, empty}
- One natural sub-module: bsg_dff_en_async_reset. This is a width_p enabled register with async active-high reset to 0, instantiated twice for mem0/mem1.
- Pointer and flag logic stay inline in the top.

Test Plan:
1. Reset then idle:
   - Stimulus: reset_i=1 for 3 cycles, release.
   - Required: during reset ready_o=0, v_o=0, data_o=0; cycle after release ready_o=1, v_o=0.
2. Single transfer:
   - Stimulus: v_i=1, data_i=13'h1ABC for one cycle, then yumi_i=1 when v_o=1.
   - Required: v_o=1 and data_o=13'h1ABC one cycle after enq; v_o=0 the cycle after yumi.
3. Fill and backpressure:
   - Stimulus: enqueue 13'h0001, 13'h0002 with yumi_i=0, then present 13'h0003.
   - Required: ready_o=0 after the second enq; 13'h0003 is not accepted.
   - Drain order: 0001, 0002. v_o=0 after both yumis.
4. Streaming:
   - Stimulus: v_i=1 and yumi_i=v_o every cycle for 20 cycles, data_i = cycle index.
   - Required: one output per cycle after a 1-cycle fill; values 0..18 in order; ready_o stays 1.
5. Simultaneous enq/deq when holding one entry:
   - Stimulus: holding 13'h0AAA; enq 13'h0BBB with yumi_i=1 in the same cycle.
   - Required: next cycle data_o=13'h0BBB, v_o=1, ready_o=1, and the pointers have wrapped.
6. Async reset mid-operation:
   - Stimulus: full with 13'h1111/13'h1222; assert reset_i between clock edges.
   - Required: v_o=0, data_o=0, ready_o=0 immediately without a clock edge.
   - After release: empty, ready_o=1; no stale data is reported.
